// File: rtl/divider32_seq_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default width, step counter width and the width-sized constants.
package divider32_seq_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH);

  localparam logic [DIV_WIDTH-1:0] ALL_ONES   = {DIV_WIDTH{1'b1}};
  localparam logic [DIV_WIDTH-1:0] SIGNED_MIN = {1'b1, {(DIV_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/divider32_seq_div_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder and subtract the divisor when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  // The shifted remainder can reach 2*divisor-1, so it keeps the bit shifted
  // out of rem_in; one more bit on top carries the sign of the difference.
  assign shifted = {rem_in, q_msb};
  assign trial   = {1'b0, shifted} - {2'b00, divisor};
  assign q_bit   = ~trial[WIDTH+1];
  assign rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/divider32_seq.sv
// Iterative signed/unsigned restoring divider: one quotient bit per clock,
// results and Z/V/N/DZ flags presented with a one-cycle done pulse.
module divider32_seq
  import divider32_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             Z,
  output logic             V,
  output logic             N,
  output logic             DZ
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] rem_reg, q_reg, d_reg;
  logic             neg_q_reg, neg_r_reg, dz_reg, v_reg;
  logic             done_reg;
  logic [WIDTH-1:0] quotient_reg, remainder_reg;
  logic             z_reg, v_out_reg, n_reg, dz_out_reg;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic [WIDTH-1:0] dividend_abs, divisor_abs;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_reg),
    .q_msb   (q_reg[WIDTH-1]),
    .divisor (d_reg),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // The done cycle still reports busy so a start held across it lands one
  // cycle later instead of overlapping the result hand-off.
  assign ready = (state_reg == ST_IDLE) && !done_reg;

  assign dividend_abs = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
  assign divisor_abs  = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start && ready) state_next = ST_RUN;
      ST_RUN:  if (cnt_reg == CNT_W'(WIDTH-1)) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    q_fix = neg_q_reg ? -q_reg : q_reg;
    if (dz_reg) q_fix = ALL_ONES;
    r_fix = neg_r_reg ? -rem_reg : rem_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      rem_reg       <= '0;
      q_reg         <= '0;
      d_reg         <= '0;
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
      dz_reg        <= 1'b0;
      v_reg         <= 1'b0;
      done_reg      <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      z_reg         <= 1'b1;
      v_out_reg     <= 1'b0;
      n_reg         <= 1'b0;
      dz_out_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start && ready) begin
            cnt_reg   <= '0;
            rem_reg   <= '0;
            q_reg     <= dividend_abs;
            d_reg     <= divisor_abs;
            neg_q_reg <= signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r_reg <= signed_op && dividend[WIDTH-1];
            dz_reg    <= (divisor == '0);
            v_reg     <= signed_op && (dividend == SIGNED_MIN) && (divisor == ALL_ONES);
          end
        end
        ST_RUN: begin
          rem_reg <= step_rem;
          q_reg   <= {q_reg[WIDTH-2:0], step_q};
          cnt_reg <= cnt_reg + 1'b1;
        end
        ST_DONE: begin
          quotient_reg  <= q_fix;
          remainder_reg <= r_fix;
          z_reg         <= (q_fix == '0);
          n_reg         <= q_fix[WIDTH-1];
          v_out_reg     <= v_reg;
          dz_out_reg    <= dz_reg;
          done_reg      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign done      = done_reg;
  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;
  assign Z         = z_reg;
  assign V         = v_out_reg;
  assign N         = n_reg;
  assign DZ        = dz_out_reg;

endmodule
